// File: rtl/cdc_top.sv
// cdc_top: toggle req/ack handshake moving one payload word from a
// send half to a receive half, each crossing through SYNC_STAGES flops.
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-high reset
//   data_i   in   payload, captured on an accepted valid_i rise
//   valid_i  in   transfer request, a 0->1 edge starts a transfer
//   data_o   out  last delivered payload, registered
//   valid_o  out  one-cycle pulse marking new data_o
//   busy_o   out  high while a transfer is in flight
//   err_o    out  sticky flag for an ignored request
//                 (only with CDC_TOP_OVERRUN_ERR_EN defined)
module cdc_top #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
`ifdef CDC_TOP_OVERRUN_ERR_EN
  output logic                  busy_o,
  output logic                  err_o
`else
  output logic                  busy_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RX,
    WAIT_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_prev_valid;
  logic                   r_armed;
  logic                   r_req;
  logic [DATA_WIDTH-1:0]  r_hold;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   r_req_seen;
  logic                   r_ack;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_valid;

  logic w_rise;
  logic w_accept;
  logic w_ack_new;
  logic w_ack_done;
  logic w_req_new;

  // r_armed blocks a start on the first edge after reset, so a
  // valid_i already high at release is never seen as a rise.
  assign w_rise   = valid_i & ~r_prev_valid & r_armed;
  assign w_accept = w_rise & (r_state == IDLE);

  // The ack change is caught one stage early (last two stages differ)
  // so WAIT_ACK can close on the fully synchronized ack next cycle.
  assign w_ack_new  = r_ack_sync[SYNC_STAGES-1]
                    ^ r_ack_sync[SYNC_STAGES-2];
  assign w_ack_done = (r_ack_sync[SYNC_STAGES-1] == r_req);

  assign w_req_new = r_req_sync[SYNC_STAGES-1] ^ r_req_seen;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept)   w_next = WAIT_RX;
      WAIT_RX:  if (w_ack_new)  w_next = WAIT_ACK;
      WAIT_ACK: if (w_ack_done) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Send half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_prev_valid <= 1'b0;
      r_armed      <= 1'b0;
      r_req        <= 1'b0;
      r_hold       <= '0;
      r_ack_sync   <= '0;
    end else begin
      r_state      <= w_next;
      r_prev_valid <= valid_i;
      r_armed      <= 1'b1;
      r_ack_sync   <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
      if (w_accept) begin
        r_hold <= data_i;
        r_req  <= ~r_req;
      end
    end
  end

  // Receive half; r_hold is stable here because it only
  // reloads in IDLE, after the previous ack has returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_sync <= '0;
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
      r_req_seen <= r_req_sync[SYNC_STAGES-1];
      r_valid    <= w_req_new;
      if (w_req_new) begin
        r_data <= r_hold;
        r_ack  <= ~r_ack;
      end
    end
  end

`ifdef CDC_TOP_OVERRUN_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_rise && r_state != IDLE) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_cdc_top.sv
// tb_cdc_top: randomized and directed bench for cdc_top against an
// event-timeline reference model.
module tb_cdc_top;

  localparam int DW = 8;
  localparam int S  = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          busy_o;
`ifdef CDC_TOP_OVERRUN_ERR_EN
  logic          err_o;
`endif

  int checks;
  int errors;

  cdc_top #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(S)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .data_i (data_i),
    .valid_i(valid_i),
    .data_o (data_o),
`ifdef CDC_TOP_OVERRUN_ERR_EN
    .valid_o(valid_o),
    .busy_o (busy_o),
    .err_o  (err_o)
`else
    .valid_o(valid_o),
    .busy_o (busy_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a transfer accepted at edge k delivers at
  // edge k+S+1 and is busy over edges k..k+2S+1. A rise is
  // accepted only if the block was idle before that edge.
  int          m_e;
  int          m_k;
  logic        m_prev;
  logic        m_armed;
  logic [DW-1:0] m_hold;
  logic        exp_valid;
  logic [DW-1:0] exp_data;
  logic        exp_busy;
  logic        exp_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_e       <= 0;
      m_k       <= -1000;
      m_prev    <= 1'b0;
      m_armed   <= 1'b0;
      m_hold    <= '0;
      exp_valid <= 1'b0;
      exp_data  <= '0;
      exp_busy  <= 1'b0;
      exp_err   <= 1'b0;
    end else begin
      automatic int e = m_e + 1;
      automatic int k = m_k;
      automatic logic [DW-1:0] h = m_hold;
      automatic logic rise = valid_i && !m_prev && m_armed;
      if (rise) begin
        if (e - 1 > k + 2*S + 1) begin
          k = e;
          h = data_i;
        end else begin
          exp_err <= 1'b1;
        end
      end
      m_e       <= e;
      m_k       <= k;
      m_hold    <= h;
      exp_valid <= (e == k + S + 1);
      if (e == k + S + 1) exp_data <= h;
      exp_busy  <= (e >= k) && (e <= k + 2*S + 1);
      m_prev    <= valid_i;
      m_armed   <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset   = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'hFF;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: v=%b d=%h b=%b want 0 00 0",
               valid_o, data_o, busy_o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: v=%b d=%h b=%b want 0 00 0",
               valid_o, data_o, busy_o);
    end
  endtask

  task automatic test_single();
    data_i  = 8'h01;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) data_i = 8'hEE;
      checks++;
      if (valid_o !== (i == 3) || busy_o !== (i <= 5)) begin
        errors++;
        $display("FAIL single_t%0d: v=%b b=%b want v=%b b=%b",
                 i, valid_o, busy_o, (i == 3), (i <= 5));
      end
    end
    checks++;
    if (data_o !== 8'h01) begin
      errors++;
      $display("FAIL single_data: got %h want 01", data_o);
    end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_hold_high();
    int pulses = 0;
    data_i  = 8'hA5;
    valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    valid_i = 1'b0;
    repeat (8) begin
      tick();
      if (valid_o) pulses++;
    end
    checks++;
    if (pulses !== 1 || data_o !== 8'hA5) begin
      errors++;
      $display("FAIL hold_high: pulses=%0d d=%h want 1 a5",
               pulses, data_o);
    end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    do_reset();
    data_i  = 8'h01;
    valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_o) pulses++;
      if (i == 0) valid_i = 1'b0;
      if (i == 1) begin
        data_i  = 8'h55;
        valid_i = 1'b1;
      end
    end
    valid_i = 1'b0;
    repeat (10) begin
      tick();
      if (valid_o) pulses++;
    end
    checks++;
    if (pulses !== 1 || data_o !== 8'h01) begin
      errors++;
      $display("FAIL overrun: pulses=%0d d=%h want 1 01",
               pulses, data_o);
    end
`ifdef CDC_TOP_OVERRUN_ERR_EN
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_err: got %b want 1", err_o);
    end
`endif
  endtask

  task automatic test_loop();
    int pulses = 0;
    for (int d = 1; d <= 16; d++) begin
      int n = 0;
      data_i  = DW'(d);
      valid_i = 1'b1;
      while (!valid_o && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (!valid_o || data_o !== DW'(d) || data_o !== exp_data) begin
        errors++;
        $display("FAIL loop_%0d: v=%b d=%h want 1 %h",
                 d, valid_o, data_o, DW'(d));
      end
      if (valid_o) pulses++;
      valid_i = 1'b0;
      repeat ($urandom_range(18, 22)) begin
        tick();
        if (valid_o) pulses++;
      end
    end
    checks++;
    if (pulses !== 16) begin
      errors++;
      $display("FAIL loop_pulses: got %0d want 16", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    do_reset();
    data_i  = 8'h3C;
    valid_i = 1'b1;
    tick();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    checks++;
    if (pulses !== 0 || data_o !== 8'h00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: p=%0d d=%h b=%b want 0 00 0",
               pulses, data_o, busy_o);
    end
  endtask

  task automatic test_release_high();
    int pulses = 0;
    int busy_seen = 0;
    @(negedge clk);
    reset   = 1'b1;
    data_i  = 8'h77;
    valid_i = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid_o) pulses++;
      if (busy_o) busy_seen++;
    end
    valid_i = 1'b0;
    tick();
    checks++;
    if (pulses !== 0 || busy_seen !== 0 || data_o !== 8'h00) begin
      errors++;
      $display("FAIL release_high: p=%0d b=%0d d=%h want 0 0 00",
               pulses, busy_seen, data_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick();
      checks++;
      if (valid_o !== exp_valid || data_o !== exp_data ||
          busy_o !== exp_busy) begin
        errors++;
        $display("FAIL rand_%0d: v=%b d=%h b=%b want %b %h %b",
                 i, valid_o, data_o, busy_o,
                 exp_valid, exp_data, exp_busy);
      end
`ifdef CDC_TOP_OVERRUN_ERR_EN
      checks++;
      if (err_o !== exp_err) begin
        errors++;
        $display("FAIL rand_err_%0d: got %b want %b",
                 i, err_o, exp_err);
      end
`endif
      data_i = DW'($urandom);
      if ($urandom_range(0, 3) == 0) valid_i = ~valid_i;
    end
    valid_i = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    test_reset();
    test_single();
    test_hold_high();
    test_overrun();
    test_loop();
    test_reset_mid();
    test_release_high();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
